// File: rtl/puzzle_loader_pkg.sv
// Shared widths, encodings and the cell visibility rule for the sudoku puzzle loader.
package puzzle_loader_pkg;

  localparam int CELLS      = 81;
  localparam int VALUE_W    = 4;
  localparam int INDEX_W    = 7;
  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 6;
  localparam int SEL_W      = 3;

  typedef enum logic {
    EASY = 1'b0,
    HARD = 1'b1
  } difficulty_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic               hide_hard;
    logic               hide_easy;
    logic [VALUE_W-1:0] value;
  } rom_word_t;

  function automatic logic value_ok(input logic [VALUE_W-1:0] v);
    return (v != '0) && (v <= 4'd9);
  endfunction

  // Hard mode hides everything easy mode hides, plus the hide_hard cells.
  function automatic logic cell_visible(input difficulty_e d, input rom_word_t w);
    return !(w.hide_easy || ((d == HARD) && w.hide_hard));
  endfunction

endpackage

// File: rtl/puzzle_loader_if.sv
// Control, ROM-read and board-write signals of the puzzle loader.
interface puzzle_loader_if;
  import puzzle_loader_pkg::*;

  logic                  start;
  logic                  abort;
  logic                  difficulty;
  logic [SEL_W-1:0]      puzzle_sel;
  logic                  rom_rd_en;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [ROM_DATA_W-1:0] rom_data;
  logic                  wr_en;
  logic [INDEX_W-1:0]    wr_index;
  logic [VALUE_W-1:0]    wr_value;
  logic                  wr_visible;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [INDEX_W-1:0]    hidden_count;

  // Game FSM, ROM and board storage side.
  modport master (
    output start, abort, difficulty, puzzle_sel, rom_data,
    input  rom_rd_en, rom_addr, wr_en, wr_index, wr_value, wr_visible,
           busy, done, error, hidden_count
  );

  // Loader side.
  modport slave (
    input  start, abort, difficulty, puzzle_sel, rom_data,
    output rom_rd_en, rom_addr, wr_en, wr_index, wr_value, wr_visible,
           busy, done, error, hidden_count
  );

endinterface

// File: rtl/rom_read_pipe.sv
// Tracks in-flight ROM reads: a LATENCY-deep valid/index shift register with flush.
module rom_read_pipe
  import puzzle_loader_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [INDEX_W-1:0] index_i,
  output logic               valid_o,
  output logic [INDEX_W-1:0] index_o
);

  logic [LATENCY-1:0] valid_q;
  logic [INDEX_W-1:0] index_q [LATENCY];

  // NOTE: non-blocking assignments so every stage shifts from the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: the index payload is qualified by valid_q, so this storage needs no reset.
  always_ff @(posedge clk) begin
    index_q[0] <= index_i;
    for (int i = 1; i < LATENCY; i++) index_q[i] <= index_q[i-1];
  end

  assign valid_o = valid_q[LATENCY-1];
  assign index_o = index_q[LATENCY-1];

endmodule

// File: rtl/puzzle_loader.sv
// Streams one 81-cell puzzle from ROM into board storage, deriving per-cell visibility
// from the difficulty latched at start.
module puzzle_loader
  import puzzle_loader_pkg::*;
#(
  parameter int PUZZLES     = 8,
  parameter int ROM_LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  puzzle_loader_if.slave bus
);

  state_e                state_q;
  difficulty_e           diff_q;
  logic [ROM_ADDR_W-1:0] base_q;
  logic [INDEX_W-1:0]    count_q;
  logic                  rom_rd_en_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic                  wr_en_q;
  logic [INDEX_W-1:0]    wr_index_q;
  logic [VALUE_W-1:0]    wr_value_q;
  logic                  wr_visible_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [INDEX_W-1:0]    hidden_q;

  logic                  pipe_valid;
  logic [INDEX_W-1:0]    pipe_index;
  logic                  flush;
  logic                  write_fire;
  logic [ROM_ADDR_W-1:0] base_w;
  rom_word_t             word;
  logic                  bad_d;
  logic [VALUE_W-1:0]    wr_value_d;
  logic                  wr_visible_d;

  assign flush      = bus.abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign write_fire = pipe_valid && !flush;
  assign base_w     = ROM_ADDR_W'(bus.puzzle_sel) * ROM_ADDR_W'(CELLS);

  rom_read_pipe #(.LATENCY(ROM_LATENCY)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .valid_i (rom_rd_en_q),
    .index_i (count_q),
    .valid_o (pipe_valid),
    .index_o (pipe_index)
  );

  // NOTE: every signal is assigned on every pass through this block, so no latch is inferred.
  always_comb begin
    word         = rom_word_t'(bus.rom_data);
    bad_d        = !value_ok(word.value);
    wr_value_d   = bad_d ? '0 : word.value;
    wr_visible_d = !bad_d && cell_visible(diff_q, word);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      diff_q       <= EASY;
      base_q       <= '0;
      count_q      <= '0;
      rom_rd_en_q  <= 1'b0;
      rom_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_index_q   <= '0;
      wr_value_q   <= '0;
      wr_visible_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      hidden_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= write_fire;
      if (write_fire) begin
        wr_index_q   <= pipe_index;
        wr_value_q   <= wr_value_d;
        wr_visible_q <= wr_visible_d;
        if (bad_d) error_q <= 1'b1;
        if (!wr_visible_d && (hidden_q != INDEX_W'(CELLS))) hidden_q <= hidden_q + 7'd1;
      end

      case (state_q)
        ST_IDLE: begin
          // Abort in the same cycle as start suppresses the load.
          if (bus.start && !bus.abort) begin
            diff_q   <= difficulty_e'(bus.difficulty);
            base_q   <= base_w;
            error_q  <= 1'b0;
            hidden_q <= '0;
            if (int'(bus.puzzle_sel) >= PUZZLES) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              count_q     <= '0;
              rom_rd_en_q <= 1'b1;
              rom_addr_q  <= base_w;
              busy_q      <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (flush) begin
            state_q     <= ST_IDLE;
            rom_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (count_q == INDEX_W'(CELLS - 1)) begin
            state_q     <= ST_DRAIN;
            rom_rd_en_q <= 1'b0;
          end else begin
            count_q    <= count_q + 7'd1;
            rom_addr_q <= base_q + ROM_ADDR_W'(count_q + 7'd1);
          end
        end
        ST_DRAIN: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (wr_en_q && (wr_index_q == INDEX_W'(CELLS - 1))) begin
            state_q <= ST_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_rd_en    = rom_rd_en_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_index     = wr_index_q;
  assign bus.wr_value     = wr_value_q;
  assign bus.wr_visible   = wr_visible_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.hidden_count = hidden_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Self-checking bench: random ROM contents, a per-cycle reference model of the load
// timeline, plus directed abort, restart and reset scenarios.
module tb_puzzle_loader;
  import puzzle_loader_pkg::*;

  localparam int L   = 2;
  localparam int PUZ = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  puzzle_loader_if bus ();

  puzzle_loader #(.PUZZLES(PUZ), .ROM_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM: data appears L cycles after the cycle in which rom_rd_en is high.
  logic [5:0] rom_mem  [1024];
  logic [5:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= bus.rom_rd_en ? rom_mem[bus.rom_addr] : 6'h00;
    for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_data = rom_pipe[L-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},  32'(bus.rom_rd_en),    0);
    check({tag, "_addr"},   32'(bus.rom_addr),     0);
    check({tag, "_wr_en"},  32'(bus.wr_en),        0);
    check({tag, "_index"},  32'(bus.wr_index),     0);
    check({tag, "_value"},  32'(bus.wr_value),     0);
    check({tag, "_vis"},    32'(bus.wr_visible),   0);
    check({tag, "_busy"},   32'(bus.busy),         0);
    check({tag, "_done"},   32'(bus.done),         0);
    check({tag, "_error"},  32'(bus.error),        0);
    check({tag, "_hidden"}, 32'(bus.hidden_count), 0);
  endtask

  // Drives one load and checks every cycle against the expected timeline:
  // read k in cycle k, write k in cycle k+L+1, done in cycle L+82.
  task automatic run_load(input int sel, input int diff, input int abort_at, input int restart_at);
    logic [3:0] e_val [CELLS];
    logic       e_vis [CELLS];
    logic [5:0] w;
    logic [3:0] v;
    logic       bad;
    int base, hid_all, err_all, hid_part, err_part;
    bit live, e_rd, e_wr, e_busy, e_done;
    base = sel * CELLS;
    hid_all = 0; err_all = 0; hid_part = 0; err_part = 0;
    for (int i = 0; i < CELLS; i++) begin
      w   = rom_mem[base + i];
      v   = w[3:0];
      bad = (v == 4'd0) || (v > 4'd9);
      e_val[i] = bad ? 4'd0 : v;
      e_vis[i] = !bad && !(w[4] || ((diff != 0) && w[5]));
      if (!e_vis[i]) hid_all++;
      if (bad) err_all = 1;
      if (abort_at >= 0 && i + L + 1 <= abort_at) begin
        if (!e_vis[i]) hid_part++;
        if (bad) err_part = 1;
      end
    end

    bus.puzzle_sel = 3'(sel);
    bus.difficulty = (diff != 0);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c <= L + 85; c++) begin
      live   = (abort_at < 0) || (c <= abort_at);
      e_rd   = live && (c <= CELLS - 1);
      e_wr   = live && (c >= L + 1) && (c <= L + CELLS);
      e_busy = live && (c <= L + CELLS);
      e_done = live && (c == L + CELLS + 1);
      check($sformatf("rd_en@%0d", c), 32'(bus.rom_rd_en), 32'(e_rd));
      check($sformatf("wr_en@%0d", c), 32'(bus.wr_en),     32'(e_wr));
      check($sformatf("busy@%0d", c),  32'(bus.busy),      32'(e_busy));
      check($sformatf("done@%0d", c),  32'(bus.done),      32'(e_done));
      if (e_rd && bus.rom_rd_en)
        check($sformatf("rom_addr@%0d", c), 32'(bus.rom_addr), 32'(base + c));
      if (e_wr && bus.wr_en) begin
        check($sformatf("wr_index@%0d", c), 32'(bus.wr_index),   32'(c - L - 1));
        check($sformatf("wr_value@%0d", c), 32'(bus.wr_value),   32'(e_val[c-L-1]));
        check($sformatf("wr_vis@%0d", c),   32'(bus.wr_visible), 32'(e_vis[c-L-1]));
      end
      if (c == 0) begin
        check("hidden_cleared", 32'(bus.hidden_count), 0);
        check("error_cleared",  32'(bus.error),        0);
      end
      if (e_done) begin
        check("hidden_final", 32'(bus.hidden_count), 32'(hid_all));
        check("error_final",  32'(bus.error),        32'(err_all));
      end
      bus.start = (c == restart_at);
      if (c == restart_at) begin
        bus.puzzle_sel = 3'(sel ^ 5);
        bus.difficulty = (diff == 0);
      end
      bus.abort = (c == abort_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (abort_at >= 0) begin
      check("hidden_partial", 32'(bus.hidden_count), 32'(hid_part));
      check("error_partial",  32'(bus.error),        32'(err_part));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    logic       he, hh;
    int         idx;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.difficulty = 1'b0;
    bus.puzzle_sel = 3'd0;

    for (int i = 0; i < 1024; i++) rom_mem[i] = 6'h00;
    for (int p = 0; p < PUZ; p++) begin
      for (int i = 0; i < CELLS; i++) begin
        idx = p * CELLS + i;
        v   = 4'($urandom_range(1, 9));
        he  = 1'($urandom_range(0, 1));
        hh  = 1'($urandom_range(0, 1));
        if (p == 0) begin
          he = (i % 3 == 0);
          hh = (i % 3 == 1);
        end else if (p == 3) begin
          if (i == 40) v = 4'hA;
        end else if ($urandom_range(0, 19) == 0) begin
          v = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(10, 15));
        end
        rom_mem[idx] = {hh, he, v};
      end
    end

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    run_load(0, 0, -1, -1);
    check("p0_easy_hidden27", 32'(bus.hidden_count), 27);
    check("p0_easy_error0",   32'(bus.error),        0);
    run_load(0, 1, -1, -1);
    check("p0_hard_hidden54", 32'(bus.hidden_count), 54);
    run_load(7, 0, -1, -1);
    run_load(3, 1, -1, -1);
    check("p3_bad_error1", 32'(bus.error), 1);
    run_load(0, 0, -1, -1);
    check("error_cleared_after", 32'(bus.error), 0);

    run_load(5, 0, 30, -1);
    run_load(5, 0, -1, -1);
    run_load(1, 0, -1, 10);

    // Start and abort together in IDLE: no load begins.
    bus.puzzle_sel = 3'd2;
    bus.start      = 1'b1;
    bus.abort      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("abort_start_rd@%0d", c),   32'(bus.rom_rd_en), 0);
      check($sformatf("abort_start_busy@%0d", c), 32'(bus.busy),      0);
      @(negedge clk);
    end

    // Reset in the middle of a load.
    bus.puzzle_sel = 3'd4;
    bus.difficulty = 1'b0;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_rd@%0d", c),   32'(bus.rom_rd_en), 0);
      check($sformatf("post_rst_wr@%0d", c),   32'(bus.wr_en),     0);
      check($sformatf("post_rst_busy@%0d", c), 32'(bus.busy),      0);
    end

    for (int t = 0; t < 5; t++) begin
      int s, d, a;
      s = int'($urandom_range(0, PUZ - 1));
      d = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, L + CELLS)) : -1;
      run_load(s, d, a, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puzzle_loader.md
Name: puzzle_loader

Overview:
Sequences the load of one sudoku puzzle from the puzzle ROM into the board/visibility storage while the game sits in the loading state. It reads 81 cells in order, derives each cell's visibility from the latched difficulty, and drives a single write port into the board storage. It reports busy, done, a sticky data error and the hidden-cell count. The game FSM pulses start on entry to loading and waits for done.

Parameters:
CELLS, 81, cells per puzzle (fixed 9x9)
PUZZLES, 8, puzzles stored in ROM
ROM_LATENCY, 2, cycles from rom_rd_en to valid rom_data (1..4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle load request
abort  in  1  cancel an in-progress load
difficulty  in  1  0=easy, 1=hard; latched at start
puzzle_sel  in  3  puzzle number; latched at start
rom_rd_en  out  1  ROM read strobe
rom_addr  out  10  puzzle_sel*81 + cell
rom_data  in  6  [3:0] value, [4] hide_easy, [5] hide_hard
wr_en  out  1  board write strobe
wr_index  out  7  cell index 0..80 (row*9+col)
wr_value  out  4  cell value 1..9 (0 on error)
wr_visible  out  1  cell shown to player
busy  out  1  load in progress
done  out  1  one-cycle completion pulse
error  out  1  sticky bad-data flag
hidden_count  out  7  number of cells written with wr_visible=0

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including hidden_count, error and rom_addr.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - When start=1 at a clock edge, latch difficulty and puzzle_sel and register base = puzzle_sel*81 (10-bit).
  - Clear error and hidden_count, then go to ISSUE.
  - If puzzle_sel >= PUZZLES: set error, pulse done in the next cycle, return to IDLE, and issue no reads.
- ISSUE:
  - In cycle k (k=0..80) after entry: rom_rd_en=1 and rom_addr=base+k.
  - A ROM_LATENCY-deep valid/index shift pipe tracks in-flight reads.
  - After k=80, go to DRAIN.
- Write timing: read issued in cycle k produces wr_en=1 in cycle k+ROM_LATENCY+1, with registered outputs:
  - wr_index=k
  - wr_value=rom_data[3:0]
  - wr_visible: easy gives ~hide_easy; hard gives ~(hide_easy|hide_hard)
  - Writes are back-to-back, exactly 81 of them, in ascending index order.
- Bad data: rom_data[3:0]==0 or >9 gives wr_value=0, wr_visible=0, and error set (sticky until next start). Loading continues.
- hidden_count increments (7-bit, no wrap; max 81) in the same cycle as each write with wr_visible=0. It is final when done pulses and holds until the next start.
- DRAIN: waits until the last write (index 80) has been issued, then goes to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- busy:
  - 1 from the first ISSUE cycle through the cycle of the last write.
  - 0 in the done cycle.
  - Total: done is asserted ROM_LATENCY+82 cycles after the first ISSUE cycle.
- start while not IDLE: ignored, and latched values are unchanged.
- abort=1 in ISSUE/DRAIN:
  - Next cycle: IDLE, busy=0, rom_rd_en=0.
  - Pipe valids are flushed, so no further wr_en.
  - No done pulse; error and hidden_count keep partial values.
- abort and start in the same IDLE cycle: abort wins, and no load starts.
- Reset mid-load: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package/header holds:
  - CELLS=81, VALUE_W=4, INDEX_W=7, ROM_ADDR_W=10
  - difficulty encodings EASY=0, HARD=1
  - loader state encodings
- One natural sub-module, rom_read_pipe: a ROM_LATENCY-deep valid+index shift register with flush. It is instantiated once.
- The visibility rule stays in puzzle_loader.

Test Plan:
- puzzle_sel=0, easy, ROM_LATENCY=2, ROM with every 3rd cell hide_easy=1 -> 81 writes in indices 0..80, first wr_en 3 cycles after first rom_rd_en, hidden_count=27, done 84 cycles after first ISSUE cycle, error=0.
- Same puzzle, hard, cells 1 mod 3 also hide_hard=1 -> hidden_count=54, wr_visible=1 only at indices 2,5,...,80.
- puzzle_sel=7 -> rom_addr runs 567..647; puzzle_sel=3 with ROM cell 40 value 0xA -> wr_value=0 at index 40, error=1, done still pulses, error clears on the next start.
- abort asserted at ISSUE cycle 30 -> no wr_en after in-flight flush, no done, busy=0 one cycle later; a new start then loads all 81 cells.
- start pulsed again at cycle 10 of a load with puzzle_sel changed -> ignored, addresses continue from the original base.
- reset driven low at cycle 50 -> all outputs 0 immediately; after release, idle until start.
